// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU types and constants for the fadd start/done issuer.
package fpu_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} fadd_issuer_state_t;
   localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
   localparam int FP_SIGN_BIT = 31;
endpackage

// File: rtl/fadd_wdog.sv
// fadd_wdog: WAIT-state cycle counter; hit_o flags the LIMIT-th counted cycle.
module fadd_wdog #(
   parameter int LIMIT = 15
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr_i,
   input  logic en_i,
   output logic hit_o
);
   localparam int CW = $clog2(LIMIT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk) cnt_q <= !rstn ? '0 : cnt_d;
   assign hit_o = en_i && cnt_q == CW'(LIMIT - 1);
endmodule

// File: rtl/fadd_issuer.sv
// fadd_issuer: holds one add/sub request on the fadd inputs, pulses start, buffers the result.
// Optional watchdog on the WAIT state enabled by defining FADD_ISSUER_WDOG_EN.
module fadd_issuer
   import fpu_pkg::*;
#(
   parameter int TAG_W      = 4,
   parameter int WDOG_LIMIT = 15
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic             op_sub,
   input  logic [31:0]      op_a,
   input  logic [31:0]      op_b,
   input  logic [TAG_W-1:0] op_tag,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      res_data,
   output logic [TAG_W-1:0] res_tag,
   output logic             res_err,
   output logic [31:0]      fu_x1,
   output logic [31:0]      fu_x2,
   output logic             fu_ready,
   input  logic             fu_valid,
   input  logic [31:0]      fu_y
);
   fadd_issuer_state_t state_q, state_d;
   logic [31:0]      x1_q, x1_d, x2_q, x2_d, data_q, data_d;
   logic [TAG_W-1:0] held_tag_q, held_tag_d, tag_q, tag_d;
   logic             valid_q, valid_d, err_q, err_d, start_q, start_d;
   logic             accept, done, wdog_hit, load;

`ifdef FADD_ISSUER_WDOG_EN
   fadd_wdog #(.LIMIT(WDOG_LIMIT)) u_wdog (
      .clk   (clk),
      .rstn  (rstn),
      .clr_i (state_q == ISSUE),
      .en_i  (state_q == WAIT),
      .hit_o (wdog_hit)
   );
`else
   assign wdog_hit = 1'b0;
`endif

   assign op_ready = state_q == IDLE && (!valid_q || res_ready);
   assign accept   = op_valid && op_ready;
   assign done     = state_q == WAIT && fu_valid;
   assign load     = done || (state_q == WAIT && wdog_hit);

   // Subtraction is only a sign flip on b; the adder does the arithmetic.
   always_comb begin
      state_d    = state_q == IDLE  ? (accept ? ISSUE : IDLE) :
                   state_q == ISSUE ? WAIT :
                   load             ? IDLE : WAIT;
      x1_d       = accept ? op_a : x1_q;
      x2_d       = accept ? {op_b[FP_SIGN_BIT] ^ op_sub, op_b[FP_SIGN_BIT-1:0]} : x2_q;
      held_tag_d = accept ? op_tag : held_tag_q;
      start_d    = accept;
      valid_d    = load ? 1'b1 : (valid_q && res_ready) ? 1'b0 : valid_q;
      data_d     = done ? fu_y : load ? FP_QNAN : data_q;
      tag_d      = load ? held_tag_q : tag_q;
      err_d      = load ? !done : err_q;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= IDLE;
         x1_q       <= '0;
         x2_q       <= '0;
         held_tag_q <= '0;
         start_q    <= 1'b0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         tag_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         x1_q       <= x1_d;
         x2_q       <= x2_d;
         held_tag_q <= held_tag_d;
         start_q    <= start_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         tag_q      <= tag_d;
         err_q      <= err_d;
      end
   end

   assign fu_x1     = x1_q;
   assign fu_x2     = x2_q;
   assign fu_ready  = start_q;
   assign res_valid = valid_q;
   assign res_data  = data_q;
   assign res_tag   = tag_q;
   assign res_err   = err_q;
endmodule

// File: tb/tb_fadd_issuer.sv
// tb_fadd_issuer: directed checks of the fadd issuer; the bench plays both requester and adder.
module tb_fadd_issuer;
   logic        clk = 1'b0, rstn = 1'b0;
   logic        op_valid = 1'b0, op_ready, op_sub = 1'b0;
   logic [31:0] op_a = '0, op_b = '0;
   logic [3:0]  op_tag = '0;
   logic        res_valid, res_ready = 1'b0;
   logic [31:0] res_data;
   logic [3:0]  res_tag;
   logic        res_err;
   logic [31:0] fu_x1, fu_x2;
   logic        fu_ready, fu_valid = 1'b0;
   logic [31:0] fu_y = '0;
   int          n_chk = 0, n_fail = 0;

   fadd_issuer #(.TAG_W(4), .WDOG_LIMIT(15)) dut (
      .clk(clk), .rstn(rstn), .op_valid(op_valid), .op_ready(op_ready), .op_sub(op_sub),
      .op_a(op_a), .op_b(op_b), .op_tag(op_tag), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_tag(res_tag), .res_err(res_err), .fu_x1(fu_x1), .fu_x2(fu_x2),
      .fu_ready(fu_ready), .fu_valid(fu_valid), .fu_y(fu_y)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Drives one request accepted immediately and answers as the adder with y two edges after start.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [3:0] tag, input logic [31:0] y);
      op_a = a; op_b = b; op_sub = sub; op_tag = tag; op_valid = 1'b1;
      cyc();
      op_valid = 1'b0;
      cyc();
      cyc();
      fu_valid = 1'b1; fu_y = y;
      cyc();
      fu_valid = 1'b0; fu_y = '0;
   endtask

   task automatic drain();
      res_ready = 1'b1;
      cyc();
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      cyc();
      cyc();
      n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
      n_chk++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_op_ready got %b exp 1", op_ready); end
      n_chk++; if (fu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_fu_ready got %b exp 0", fu_ready); end
      n_chk++; if ({res_data, fu_x1, fu_x2} !== 96'h0) begin n_fail++; $display("FAIL reset_regs got %h/%h/%h exp 0", res_data, fu_x1, fu_x2); end
      n_chk++; if ({res_err, res_tag} !== 5'h0) begin n_fail++; $display("FAIL reset_err_tag got %b/%h exp 0/0", res_err, res_tag); end
      rstn = 1'b1;
      cyc();
   endtask

   task automatic test_add();
      op_a = 32'h3F80_0000; op_b = 32'h4000_0000; op_sub = 1'b0; op_tag = 4'd5; op_valid = 1'b1;
      n_chk++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL add_op_ready got %b exp 1", op_ready); end
      cyc();
      op_valid = 1'b0;
      n_chk++; if (fu_ready !== 1'b1) begin n_fail++; $display("FAIL add_start_e0 got %b exp 1", fu_ready); end
      n_chk++; if (fu_x1 !== 32'h3F80_0000 || fu_x2 !== 32'h4000_0000) begin n_fail++; $display("FAIL add_operands got %h/%h exp 3f800000/40000000", fu_x1, fu_x2); end
      n_chk++; if (op_ready !== 1'b0) begin n_fail++; $display("FAIL add_busy_op_ready got %b exp 0", op_ready); end
      cyc();
      n_chk++; if (fu_ready !== 1'b0) begin n_fail++; $display("FAIL add_start_e1 got %b exp 0", fu_ready); end
      cyc();
      n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL add_early_valid got %b exp 0", res_valid); end
      fu_valid = 1'b1; fu_y = 32'h4040_0000;
      cyc();
      fu_valid = 1'b0; fu_y = '0;
      n_chk++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL add_res_valid_e3 got %b exp 1", res_valid); end
      n_chk++; if (res_data !== 32'h4040_0000) begin n_fail++; $display("FAIL add_res_data got %h exp 40400000", res_data); end
      n_chk++; if (res_tag !== 4'd5 || res_err !== 1'b0) begin n_fail++; $display("FAIL add_tag_err got %h/%b exp 5/0", res_tag, res_err); end
      n_chk++; if (fu_x1 !== 32'h3F80_0000) begin n_fail++; $display("FAIL add_x1_hold got %h exp 3f800000", fu_x1); end
      drain();
      n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain got %b exp 0", res_valid); end
   endtask

   task automatic test_sub();
      run_op(32'h4040_0000, 32'h3F80_0000, 1'b1, 4'd3, 32'h4000_0000);
      n_chk++; if (fu_x2 !== 32'hBF80_0000) begin n_fail++; $display("FAIL sub_x2 got %h exp bf800000", fu_x2); end
      n_chk++; if (res_data !== 32'h4000_0000 || res_tag !== 4'd3) begin n_fail++; $display("FAIL sub_result got %h/%h exp 40000000/3", res_data, res_tag); end
      drain();
   endtask

   task automatic test_zero();
      run_op(32'h0000_0000, 32'h40A0_0000, 1'b1, 4'd9, 32'hC0A0_0000);
      n_chk++; if (fu_x1 !== 32'h0 || fu_x2 !== 32'hC0A0_0000) begin n_fail++; $display("FAIL zero_operands got %h/%h exp 0/c0a00000", fu_x1, fu_x2); end
      n_chk++; if (res_data !== 32'hC0A0_0000 || res_valid !== 1'b1) begin n_fail++; $display("FAIL zero_result got %h/%b exp c0a00000/1", res_data, res_valid); end
   endtask

   task automatic test_backpressure();
      op_a = 32'h4000_0000; op_b = 32'h4000_0000; op_sub = 1'b0; op_tag = 4'd2; op_valid = 1'b1;
      n_chk++; if (op_ready !== 1'b0) begin n_fail++; $display("FAIL bp_op_ready_full got %b exp 0", op_ready); end
      cyc();
      n_chk++; if (res_valid !== 1'b1 || res_data !== 32'hC0A0_0000 || res_tag !== 4'd9) begin n_fail++; $display("FAIL bp_hold got %b/%h/%h exp 1/c0a00000/9", res_valid, res_data, res_tag); end
      n_chk++; if (fu_ready !== 1'b0 || op_ready !== 1'b0) begin n_fail++; $display("FAIL bp_no_accept got %b/%b exp 0/0", fu_ready, op_ready); end
      res_ready = 1'b1;
      #1;
      n_chk++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_op_ready got %b exp 1", op_ready); end
      cyc();
      op_valid = 1'b0; res_ready = 1'b0;
      n_chk++; if (fu_ready !== 1'b1 || res_valid !== 1'b0 || fu_x1 !== 32'h4000_0000) begin n_fail++; $display("FAIL bp_accept got %b/%b/%h exp 1/0/40000000", fu_ready, res_valid, fu_x1); end
      cyc();
      cyc();
      fu_valid = 1'b1; fu_y = 32'h4080_0000;
      cyc();
      fu_valid = 1'b0; fu_y = '0;
      n_chk++; if (res_data !== 32'h4080_0000 || res_tag !== 4'd2) begin n_fail++; $display("FAIL bp_second_result got %h/%h exp 40800000/2", res_data, res_tag); end
      drain();
   endtask

   task automatic test_mid_reset();
      op_a = 32'h3F80_0000; op_b = 32'h4000_0000; op_sub = 1'b0; op_tag = 4'd7; op_valid = 1'b1;
      cyc();
      op_valid = 1'b0;
      cyc();
      cyc();
      rstn = 1'b0;
      cyc();
      rstn = 1'b1;
      n_chk++; if (res_valid !== 1'b0 || op_ready !== 1'b1 || fu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctrl got %b/%b/%b exp 0/1/0", res_valid, op_ready, fu_ready); end
      n_chk++; if (fu_x1 !== 32'h0 || fu_x2 !== 32'h0) begin n_fail++; $display("FAIL rst_mid_operands got %h/%h exp 0/0", fu_x1, fu_x2); end
      run_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, 4'd1, 32'h4000_0000);
      n_chk++; if (res_valid !== 1'b1 || res_data !== 32'h4000_0000 || res_tag !== 4'd1) begin n_fail++; $display("FAIL rst_fresh_result got %b/%h/%h exp 1/40000000/1", res_valid, res_data, res_tag); end
      drain();
   endtask

   task automatic test_wdog();
      op_a = 32'h3F80_0000; op_b = 32'h3F80_0000; op_sub = 1'b0; op_tag = 4'hA; op_valid = 1'b1;
      cyc();
      op_valid = 1'b0;
      for (int i = 1; i < 16; i++) cyc();
      n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL wdog_early got %b exp 0", res_valid); end
      cyc();
`ifdef FADD_ISSUER_WDOG_EN
      n_chk++; if (res_valid !== 1'b1 || res_err !== 1'b1) begin n_fail++; $display("FAIL wdog_fire got %b/%b exp 1/1", res_valid, res_err); end
      n_chk++; if (res_data !== 32'h7FC0_0000 || res_tag !== 4'hA) begin n_fail++; $display("FAIL wdog_data got %h/%h exp 7fc00000/a", res_data, res_tag); end
      n_chk++; if (op_ready !== 1'b0) begin n_fail++; $display("FAIL wdog_full_op_ready got %b exp 0", op_ready); end
`else
      n_chk++; if (res_valid !== 1'b0 || res_err !== 1'b0) begin n_fail++; $display("FAIL nowdog_wait got %b/%b exp 0/0", res_valid, res_err); end
      fu_valid = 1'b1; fu_y = 32'h4000_0000;
      cyc();
      fu_valid = 1'b0; fu_y = '0;
      n_chk++; if (res_valid !== 1'b1 || res_data !== 32'h4000_0000 || res_tag !== 4'hA || res_err !== 1'b0) begin n_fail++; $display("FAIL nowdog_late_result got %b/%h/%h/%b exp 1/40000000/a/0", res_valid, res_data, res_tag, res_err); end
`endif
      drain();
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_zero();
      test_backpressure();
      test_mid_reset();
      test_wdog();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
